store_data_packer: RTL and testbench

//  Write-side counterpart of the load sign-extension path: narrows a 32-bit store operand to
//  SB/SH/SW size, shifts it into the correct byte lanes and generates byte strobes.

---
 rtl/store_data_packer.sv | 165 ++++++++++++++++
 tb/tb_store_data_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_data_packer.sv
// store_data_packer
//   Narrows a 32-bit store operand to byte/half/word size, shifts it into its byte lanes and
//   produces byte strobes for a word-wide data-memory write port. Stores that straddle a word
//   boundary become two word-aligned beats, or an error if splitting is disabled.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     store request handshake from execute
//   req_addr            byte address of the store
//   req_data            store operand (bits above the access size are ignored)
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   mem_valid/ready     write-beat handshake to data memory
//   mem_addr            word-aligned beat address
//   mem_wdata           lane-shifted write data
//   mem_wstrb           byte strobes
//   done                one-cycle pulse once the whole store has been written
//   err                 one-cycle pulse for an illegal size or a disallowed misaligned store

module store_data_packer #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH       = 32,   // only 32 is supported
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [1:0]              req_size,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StFlag} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [StrbW-1:0]        mem_wstrb_q, mem_wstrb_d;
  logic [DATA_WIDTH-1:0]   hi_wdata_q, hi_wdata_d;
  logic [StrbW-1:0]        hi_wstrb_q, hi_wstrb_d;
  logic                    done_q, done_d;

  // Request packing
  logic [DATA_WIDTH-1:0]   trunc_data;
  logic [StrbW-1:0]        size_mask;
  logic [2*DATA_WIDTH-1:0] lane_data;
  logic [2*StrbW-1:0]      lane_strb;
  logic                    crossing;
  logic                    illegal;

  always_comb begin
    trunc_data = '0;
    size_mask  = '0;
    case (req_size)
      2'b00: begin
        trunc_data[7:0] = req_data[7:0];
        size_mask[0]    = 1'b1;
      end
      2'b01: begin
        trunc_data[15:0] = req_data[15:0];
        size_mask[1:0]   = 2'b11;
      end
      2'b10: begin
        trunc_data = req_data;
        size_mask  = '1;
      end
      default: ;
    endcase
  end

  // Two-word lane window: the low half is beat 0, the high half spills into beat 1.
  assign lane_data = {{DATA_WIDTH{1'b0}}, trunc_data} << {req_addr[1:0], 3'b000};
  assign lane_strb = {{StrbW{1'b0}}, size_mask} << req_addr[1:0];
  assign crossing  = |lane_strb[2*StrbW-1:StrbW];
  assign illegal   = (req_size == 2'b11) || (crossing && !SPLIT_MISALIGNED);

  // FSM
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    hi_wdata_d  = hi_wdata_q;
    hi_wstrb_d  = hi_wstrb_q;
    done_d      = 1'b0;

    unique case (state_q)
      // FLAG is the cycle that reports err; it accepts requests exactly like IDLE so that an
      // error costs no throughput and req_ready stays high alongside the err pulse.
      StIdle, StFlag: begin
        state_d = StIdle;
        if (req_valid) begin
          if (illegal) begin
            state_d = StFlag;
          end else begin
            state_d     = StBeat0;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = lane_data[DATA_WIDTH-1:0];
            mem_wstrb_d = lane_strb[StrbW-1:0];
            hi_wdata_d  = lane_data[2*DATA_WIDTH-1:DATA_WIDTH];
            hi_wstrb_d  = lane_strb[2*StrbW-1:StrbW];
          end
        end
      end
      StBeat0: begin
        if (mem_ready) begin
          if (|hi_wstrb_q) begin
            state_d     = StBeat1;
            mem_addr_d  = mem_addr_q + ADDR_WIDTH'(4);  // wraps at the top of the address space
            mem_wdata_d = hi_wdata_q;
            mem_wstrb_d = hi_wstrb_q;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StBeat1: begin
        if (mem_ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      hi_wdata_q  <= '0;
      hi_wstrb_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      hi_wdata_q  <= hi_wdata_d;
      hi_wstrb_q  <= hi_wstrb_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = (state_q == StIdle) || (state_q == StFlag);
  assign mem_valid = (state_q == StBeat0) || (state_q == StBeat1);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign done      = done_q;
  assign err       = (state_q == StFlag);

endmodule

// File: tb/tb_store_data_packer.sv
module tb_store_data_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_valid_ns = 1'b0;
  logic [31:0] req_addr = '0, req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_ready = 1'b1;

  logic        req_ready, mem_valid, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        req_ready_ns, mem_valid_ns, done_ns, err_ns;
  logic [31:0] mem_addr_ns, mem_wdata_ns;
  logic [3:0]  mem_wstrb_ns;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_data_packer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .done(done), .err(err)
  );

  store_data_packer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid_ns), .mem_ready(mem_ready), .mem_addr(mem_addr_ns),
    .mem_wdata(mem_wdata_ns), .mem_wstrb(mem_wstrb_ns), .done(done_ns), .err(err_ns)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected write beats, consumed as the DUT completes handshakes.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;
  beat_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {mem_addr, mem_wdata}, 64'h0);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_addr", mem_addr, b.a);
        chk("beat_wdata", mem_wdata, b.d);
        chk("beat_wstrb", mem_wstrb, b.s);
      end
    end
  end

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          nbeats;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic [31:0] a1, d1;
    logic [3:0]  s1;
    bit          exp_err;
    int          lat;     // edges after the accepting edge until done/err is visible
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    req_size  = v.size;
    req_addr  = v.addr;
    req_data  = v.data;
    req_valid = 1'b1;
    if (v.nbeats >= 1) exp_q.push_back('{a: v.a0, d: v.d0, s: v.s0});
    if (v.nbeats >= 2) exp_q.push_back('{a: v.a1, d: v.d1, s: v.s1});
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!(done || err) && k < 9) begin
      @(posedge clk); #1;
      k++;
    end
    chk($sformatf("v%0d_latency", idx), 64'(k), 64'(v.lat));
    chk($sformatf("v%0d_err", idx), 64'(err), 64'(v.exp_err));
    chk($sformatf("v%0d_done", idx), 64'(done), 64'(!v.exp_err));
    chk($sformatf("v%0d_req_ready", idx), 64'(req_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            size   addr          data          n  a0            d0            s0
    //            a1            d1            s1     err lat
    vecs[0] = '{2'd0, 32'h0000_1003, 32'hDEAD_BEEF, 1, 32'h0000_1000, 32'hEF00_0000, 4'b1000,
                32'h0, 32'h0, 4'h0, 1'b0, 1};
    vecs[1] = '{2'd1, 32'h0000_1003, 32'h0000_CAFE, 2, 32'h0000_1000, 32'hFE00_0000, 4'b1000,
                32'h0000_1004, 32'h0000_00CA, 4'b0001, 1'b0, 2};
    vecs[2] = '{2'd2, 32'hFFFF_FFFE, 32'h1122_3344, 2, 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100,
                32'h0000_0000, 32'h0000_1122, 4'b0011, 1'b0, 2};
    vecs[3] = '{2'd3, 32'h0000_0040, 32'h1234_5678, 0, 32'h0, 32'h0, 4'h0,
                32'h0, 32'h0, 4'h0, 1'b1, 0};
    vecs[4] = '{2'd0, 32'h0000_2001, 32'h1234_5678, 1, 32'h0000_2000, 32'h0000_7800, 4'b0010,
                32'h0, 32'h0, 4'h0, 1'b0, 1};
    vecs[5] = '{2'd1, 32'h0000_2002, 32'hABCD_1234, 1, 32'h0000_2000, 32'h1234_0000, 4'b1100,
                32'h0, 32'h0, 4'h0, 1'b0, 1};
    vecs[6] = '{2'd2, 32'h0000_3000, 32'hCAFE_BABE, 1, 32'h0000_3000, 32'hCAFE_BABE, 4'b1111,
                32'h0, 32'h0, 4'h0, 1'b0, 1};
    vecs[7] = '{2'd2, 32'h0000_3001, 32'hAABB_CCDD, 2, 32'h0000_3000, 32'hBBCC_DD00, 4'b1110,
                32'h0000_3004, 32'h0000_00AA, 4'b0001, 1'b0, 2};
    vecs[8] = '{2'd1, 32'h0000_3001, 32'hFFFF_8001, 1, 32'h0000_3000, 32'h0080_0100, 4'b0110,
                32'h0, 32'h0, 4'h0, 1'b0, 1};
    vecs[9] = '{2'd0, 32'h0000_0000, 32'hFFFF_FF80, 1, 32'h0000_0000, 32'h0000_0080, 4'b0001,
                32'h0, 32'h0, 4'h0, 1'b0, 1};

    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, issued back-to-back in each completion cycle
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    @(posedge clk); #1;
    chk("table_beats_drained", exp_q.size(), 0);

    // Backpressure: beat held stable for 5 stalled cycles
    mem_ready = 1'b0;
    req_size = 2'd2; req_addr = 32'h10; req_data = 32'h55AA_33CC; req_valid = 1'b1;
    exp_q.push_back('{a: 32'h10, d: 32'h55AA_33CC, s: 4'b1111});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), mem_valid, 1);
      chk($sformatf("stall%0d_addr", i), mem_addr, 32'h10);
      chk($sformatf("stall%0d_wdata", i), mem_wdata, 32'h55AA_33CC);
      chk($sformatf("stall%0d_wstrb", i), mem_wstrb, 4'b1111);
      chk($sformatf("stall%0d_ready", i), req_ready, 0);
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_done", done, 1);
    chk("stall_valid_after", mem_valid, 0);
    chk("stall_beats_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("stall_done_pulse", done, 0);

    // Splitting disabled: crossing stores flag err without a beat, aligned ones still write
    req_size = 2'd2; req_addr = 32'h2; req_data = 32'h0BAD_F00D; req_valid_ns = 1'b1;
    @(posedge clk); #1;
    req_valid_ns = 1'b0;
    chk("ns_sw_err", err_ns, 1);
    chk("ns_sw_no_beat", mem_valid_ns, 0);
    chk("ns_sw_ready", req_ready_ns, 1);
    @(posedge clk); #1;
    chk("ns_sw_err_pulse", err_ns, 0);
    chk("ns_sw_no_beat2", mem_valid_ns, 0);
    req_size = 2'd1; req_addr = 32'h3; req_data = 32'h0000_BEEF; req_valid_ns = 1'b1;
    @(posedge clk); #1;
    req_valid_ns = 1'b0;
    chk("ns_sh_err", err_ns, 1);
    chk("ns_sh_no_beat", mem_valid_ns, 0);
    req_size = 2'd2; req_addr = 32'h4; req_data = 32'h0102_0304; req_valid_ns = 1'b1;
    @(posedge clk); #1;
    req_valid_ns = 1'b0;
    chk("ns_ok_valid", mem_valid_ns, 1);
    chk("ns_ok_addr", mem_addr_ns, 32'h4);
    chk("ns_ok_wdata", mem_wdata_ns, 32'h0102_0304);
    chk("ns_ok_wstrb", mem_wstrb_ns, 4'b1111);
    chk("ns_ok_err", err_ns, 0);
    @(posedge clk); #1;
    chk("ns_ok_done", done_ns, 1);

    // Async reset during the second beat drops the store silently
    req_size = 2'd1; req_addr = 32'h1003; req_data = 32'h0000_CAFE; req_valid = 1'b1;
    exp_q.push_back('{a: 32'h1000, d: 32'hFE00_0000, s: 4'b1000});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("rstmid_beat1_valid", mem_valid, 1);
    chk("rstmid_beat1_addr", mem_addr, 32'h1004);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid_drop", mem_valid, 0);
    chk("rstmid_ready", req_ready, 1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstmid%0d_done", i), done, 0);
      chk($sformatf("rstmid%0d_err", i), err, 0);
      chk($sformatf("rstmid%0d_ready", i), req_ready, 1);
      chk($sformatf("rstmid%0d_valid", i), mem_valid, 0);
      @(posedge clk); #1;
    end
    chk("final_beats_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
